response_streamer: RTL and testbench

RESPONSE_STREAMER -- requirements
Module: response_streamer

---
 rtl/puf_stream_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/response_streamer.sv | 254 +++++++++++++++++++++++++
 tb/tb_response_streamer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_stream_pkg.sv
// rtl/puf_stream_pkg.sv - shared types and helpers for the response streamer
package puf_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAIL_HI,
        ST_TRAIL_LO,
        ST_CHECKSUM,
        ST_DONE
    } state_e;

    typedef enum logic {
        MODE_WORD = 1'b0,
        MODE_BIT  = 1'b1
    } mode_e;

    localparam logic [7:0] DEFAULT_RESPONSE_ID = 8'b1010_1011;

    // Number of UART bytes needed to carry one kept response word.
    function automatic int bytes_per_word(input int response_bits, input int data_bits);
        return (response_bits + data_bits - 1) / data_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with clear, first-word fall-through read
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; a clear empties the FIFO regardless of traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/response_streamer.sv
// rtl/response_streamer.sv - frames averaged PUF responses into a checksummed UART byte stream
module response_streamer
    import puf_stream_pkg::*;
#(
    parameter int         TOT_CNT_BITS  = 33,
    parameter int         AVG_SHIFT     = 1,
    parameter int         RESPONSE_BITS = 32,
    parameter int         DATA_BITS     = 8,
    parameter int         DEPTH         = 64,
    parameter logic [7:0] RESPONSE_ID   = DEFAULT_RESPONSE_ID
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [TOT_CNT_BITS-1:0] in_data,
    input  logic                    in_last,
    output logic [DATA_BITS-1:0]    tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    frame_done,
    output logic                    overflow
);
    localparam int BPW   = bytes_per_word(RESPONSE_BITS, DATA_BITS);
    localparam int SER_W = BPW * DATA_BITS;
    localparam int CW    = $clog2(BPW + 1);
    localparam int PW    = $clog2(DATA_BITS + 1);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic                    last_seen_q, last_seen_d;
    logic                    have_first_q, have_first_d;
    logic [TOT_CNT_BITS-1:0] first_q, first_d;
    logic [DATA_BITS-1:0]    pack_q, pack_d;
    logic [PW-1:0]           pack_n_q, pack_n_d;
    logic                    wr_pend_q, wr_pend_d;
    logic [SER_W-1:0]        wr_data_q, wr_data_d;
    logic                    overflow_q, overflow_d;
    logic [SER_W-1:0]        ser_q, ser_d;
    logic [CW-1:0]           ser_cnt_q, ser_cnt_d;
    logic [15:0]             count_q, count_d;
    logic [DATA_BITS-1:0]    checksum_q, checksum_d;
    logic [DATA_BITS-1:0]    tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    frame_done_q, frame_done_d;

    logic [TOT_CNT_BITS-1:0] shifted;
    logic                    start_ok, in_accept, tx_fire, cmp_bit;
    logic [DATA_BITS-1:0]    pack_tmp;
    logic [PW-1:0]           n_tmp;
    logic                    fifo_rd, fifo_full, fifo_empty;
    logic [SER_W-1:0]        fifo_rdata;

    assign shifted   = in_data >> AVG_SHIFT;
    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_accept = in_valid && !last_seen_q && (state_q == ST_HEADER || state_q == ST_PAYLOAD);
    assign tx_fire   = tx_valid_q && tx_ready;

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    sync_fifo #(
        .WIDTH (SER_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_ok),
        .wr_en   (wr_pend_q),
        .wr_data (wr_data_q),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Input side: shift/truncate words or pair-compare into packed bits, staging one FIFO write.
    always_comb begin
        mode_d       = mode_q;
        last_seen_d  = last_seen_q;
        have_first_d = have_first_q;
        first_d      = first_q;
        pack_d       = pack_q;
        pack_n_d     = pack_n_q;
        wr_pend_d    = 1'b0;
        wr_data_d    = '0;
        overflow_d   = overflow_q | (wr_pend_q && fifo_full);
        cmp_bit      = first_q > shifted;
        pack_tmp     = pack_q;
        n_tmp        = pack_n_q;
        if (start_ok) begin
            mode_d       = mode ? MODE_BIT : MODE_WORD;
            last_seen_d  = 1'b0;
            have_first_d = 1'b0;
            pack_d       = '0;
            pack_n_d     = '0;
            overflow_d   = 1'b0;
        end else if (in_accept) begin
            last_seen_d = in_last;
            if (mode_q == MODE_WORD) begin
                wr_pend_d = 1'b1;
                wr_data_d = SER_W'(shifted[RESPONSE_BITS-1:0]);
            end else begin
                if (have_first_q) begin
                    pack_tmp     = pack_q | ({cmp_bit, {(DATA_BITS-1){1'b0}}} >> pack_n_q);
                    n_tmp        = pack_n_q + PW'(1);
                    have_first_d = 1'b0;
                end else begin
                    // An unpaired final input is simply never paired.
                    first_d      = shifted;
                    have_first_d = !in_last;
                end
                if (n_tmp == PW'(DATA_BITS) || (in_last && n_tmp != '0)) begin
                    wr_pend_d = 1'b1;
                    wr_data_d = SER_W'(pack_tmp);
                    pack_d    = '0;
                    pack_n_d  = '0;
                end else begin
                    pack_d   = pack_tmp;
                    pack_n_d = n_tmp;
                end
            end
        end
    end

    // Frame FSM: loads one byte into the output register whenever it is empty, advances on transfer.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        ser_d        = ser_q;
        ser_cnt_d    = ser_cnt_q;
        count_d      = count_q;
        checksum_d   = checksum_q;
        fifo_rd      = 1'b0;
        if (tx_fire) begin
            tx_valid_d = 1'b0;
            checksum_d = checksum_q ^ tx_data_q;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d    = ST_HEADER;
                    count_d    = '0;
                    checksum_d = '0;
                    ser_cnt_d  = '0;
                    ser_d      = '0;
                end
            end
            ST_HEADER: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = DATA_BITS'(RESPONSE_ID);
                end else if (tx_fire) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!tx_valid_q) begin
                    if (ser_cnt_q != '0) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = ser_q[SER_W-1 -: DATA_BITS];
                        ser_d      = ser_q << DATA_BITS;
                        ser_cnt_d  = ser_cnt_q - CW'(1);
                    end else if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        count_d = count_q + 16'd1;
                        if (mode_q == MODE_WORD) begin
                            ser_d     = fifo_rdata;
                            ser_cnt_d = CW'(BPW);
                        end else begin
                            ser_d     = fifo_rdata << (SER_W - DATA_BITS);
                            ser_cnt_d = CW'(1);
                        end
                    end else if (last_seen_q && !wr_pend_q) begin
                        state_d = ST_TRAIL_HI;
                    end
                end
            end
            ST_TRAIL_HI: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = DATA_BITS'(count_q[15:8]);
                end else if (tx_fire) begin
                    state_d = ST_TRAIL_LO;
                end
            end
            ST_TRAIL_LO: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = DATA_BITS'(count_q[7:0]);
                end else if (tx_fire) begin
                    state_d = ST_CHECKSUM;
                end
            end
            ST_CHECKSUM: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = checksum_q;
                end else if (tx_fire) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any frame and drops the byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_WORD;
            last_seen_q  <= 1'b0;
            have_first_q <= 1'b0;
            first_q      <= '0;
            pack_q       <= '0;
            pack_n_q     <= '0;
            wr_pend_q    <= 1'b0;
            wr_data_q    <= '0;
            overflow_q   <= 1'b0;
            ser_q        <= '0;
            ser_cnt_q    <= '0;
            count_q      <= '0;
            checksum_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            last_seen_q  <= last_seen_d;
            have_first_q <= have_first_d;
            first_q      <= first_d;
            pack_q       <= pack_d;
            pack_n_q     <= pack_n_d;
            wr_pend_q    <= wr_pend_d;
            wr_data_q    <= wr_data_d;
            overflow_q   <= overflow_d;
            ser_q        <= ser_d;
            ser_cnt_q    <= ser_cnt_d;
            count_q      <= count_d;
            checksum_q   <= checksum_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_response_streamer.sv
// tb/tb_response_streamer.sv - self-checking bench for response_streamer
module tb_response_streamer;
    localparam int DEPTH = 64;
    localparam int AVG   = 1;

    logic        clk = 1'b0;
    logic        reset, start, mode, in_valid, in_last, tx_ready;
    logic [32:0] in_data;
    logic [7:0]  tx_data;
    logic        tx_valid, frame_done, overflow;

    always #5 clk = ~clk;

    response_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic             m;
        int               n;
        logic [15:0][32:0] din;
        int               nexp;
        logic [95:0]      exp;
    } vec_t;

    vec_t        tbl [7];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ready_mode;
    int          fd_cnt;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    logic [32:0] din_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then drive tx_ready after the rising edge.
    task automatic step();
        @(negedge clk);
        if (prev_stall) begin
            check("stall_valid", 64'(tx_valid), 64'(1));
            check("stall_data", 64'(tx_data), 64'(prev_data));
        end
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (frame_done) fd_cnt++;
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = !tx_ready;
            2:       tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = 1'b0;
        endcase
    endtask

    // Reference frame built straight from the framing rules.
    function automatic void model(input logic m, input int nin);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        int          cnt;
        int          np;
        exp_q.delete();
        exp_q.push_back(8'hAB);
        if (!m) begin
            cnt = nin;
            for (int i = 0; i < nin; i++) begin
                w = 32'(din_q[i] >> AVG);
                for (int k = 3; k >= 0; k--) exp_q.push_back(8'(w >> (8 * k)));
            end
        end else begin
            np  = nin / 2;
            cnt = (np + 7) / 8;
            for (int j = 0; j < cnt; j++) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    if (j * 8 + k < np &&
                        (din_q[2 * (j * 8 + k)] >> AVG) > (din_q[2 * (j * 8 + k) + 1] >> AVG))
                        b[7 - k] = 1'b1;
                end
                exp_q.push_back(b);
            end
        end
        exp_q.push_back(8'(cnt >> 8));
        exp_q.push_back(8'(cnt));
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
    endfunction

    task automatic send_frame(input logic m, input int gap_pct, input bit start_with_last);
        rx_q.delete();
        fd_cnt = 0;
        start  = 1'b1;
        mode   = m;
        step();
        start  = 1'b0;
        mode   = 1'b0;
        for (int i = 0; i < din_q.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step();
            in_valid = 1'b1;
            in_data  = din_q[i];
            in_last  = (i == din_q.size() - 1);
            if (start_with_last && in_last) start = 1'b1;
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, input int inject_at);
        int k = 0;
        bit injected = 0;
        while (fd_cnt == 0 && k < bound) begin
            if (!injected && inject_at >= 0 && rx_q.size() >= inject_at) begin
                start    = 1'b1;
                injected = 1;
            end
            step();
            start = 1'b0;
            k++;
        end
        check("frame_done_seen", 64'(fd_cnt != 0), 64'(1));
        repeat (8) step();
        check("frame_done_pulses", 64'(fd_cnt), 64'(1));
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    endtask

    task automatic load_vec(input int v);
        din_q.delete();
        exp_q.delete();
        for (int i = 0; i < tbl[v].n; i++) din_q.push_back(tbl[v].din[i]);
        for (int i = 0; i < tbl[v].nexp; i++) exp_q.push_back(tbl[v].exp[95 - 8 * i -: 8]);
    endtask

    task automatic set_vec(input int v, input logic m, input int n, input int nexp, input logic [95:0] e);
        tbl[v].m    = m;
        tbl[v].n    = n;
        tbl[v].nexp = nexp;
        tbl[v].exp  = e;
        tbl[v].din  = '0;
    endtask

    initial begin
        logic [32:0] d;
        logic        rm;
        int          k;

        reset = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; tx_ready = 1'b0; ready_mode = 0; prev_stall = 0; fd_cnt = 0;

        // Hand-derived frames: {mode, inputs} -> exact byte stream.
        set_vec(0, 1'b0, 2, 12, 96'hAB000000028000000100022A);
        tbl[0].din[0] = 33'h0_0000_0004; tbl[0].din[1] = 33'h1_0000_0003;
        set_vec(1, 1'b1, 9, 5, {40'hAB9000013A, 56'h0});
        tbl[1].din[0] = 33'd10; tbl[1].din[1] = 33'd5; tbl[1].din[2] = 33'd3;
        tbl[1].din[3] = 33'd7;  tbl[1].din[4] = 33'd8; tbl[1].din[5] = 33'd8;
        tbl[1].din[6] = 33'd9;  tbl[1].din[7] = 33'd1; tbl[1].din[8] = 33'd4;
        set_vec(2, 1'b1, 1, 4, {32'hAB0000AB, 64'h0});
        tbl[2].din[0] = 33'd7;
        set_vec(3, 1'b0, 1, 8, {64'hABFFFFFFFF0001AA, 32'h0});
        tbl[3].din[0] = 33'h1_FFFF_FFFF;
        set_vec(4, 1'b1, 2, 5, {40'hAB000001AA, 56'h0});
        tbl[4].din[0] = 33'd2; tbl[4].din[1] = 33'd3;
        set_vec(5, 1'b0, 1, 8, {64'hAB000000000001AA, 32'h0});
        tbl[5].din[0] = 33'd1;
        set_vec(6, 1'b1, 16, 5, {40'hABFF000155, 56'h0});
        for (int i = 0; i < 16; i++) tbl[6].din[i] = (i % 2 == 0) ? 33'd9 : 33'd2;

        repeat (3) step();
        check("reset_tx_valid", 64'(tx_valid), 64'(0));
        check("reset_tx_data", 64'(tx_data), 64'(0));
        check("reset_frame_done", 64'(frame_done), 64'(0));
        check("reset_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            load_vec(v);
            send_frame(tbl[v].m, 0, 0);
            wait_done(2000, -1);
            compare_rx($sformatf("vec%0d", v));
            check($sformatf("vec%0d_overflow", v), 64'(overflow), 64'(0));
        end

        // Ready toggling every cycle: same bytes, stalled byte held stable.
        ready_mode = 1;
        load_vec(0);
        send_frame(1'b0, 0, 0);
        wait_done(2000, -1);
        compare_rx("toggle");
        ready_mode = 0;

        // Burst of DEPTH+5 words against a stalled UART.
        din_q.delete();
        for (int i = 0; i < DEPTH + 5; i++) din_q.push_back({1'b0, $urandom});
        model(1'b0, DEPTH);
        ready_mode = 3;
        send_frame(1'b0, 0, 0);
        repeat (4) step();
        check("ovf_flag", 64'(overflow), 64'(1));
        ready_mode = 0;
        wait_done(4000, -1);
        compare_rx("ovf");
        if (rx_q.size() >= 3)
            check("ovf_count", 64'({rx_q[rx_q.size() - 3], rx_q[rx_q.size() - 2]}), 64'(DEPTH));
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Start asserted alongside in_last and again mid-payload: both ignored.
        din_q.delete();
        for (int i = 0; i < 8; i++) din_q.push_back({1'($urandom_range(0, 1)), $urandom});
        model(1'b0, 8);
        send_frame(1'b0, 0, 1);
        wait_done(2000, 3);
        compare_rx("start_busy");
        check("start_busy_overflow", 64'(overflow), 64'(0));

        // Reset while streaming payload.
        din_q.delete();
        for (int i = 0; i < 8; i++) din_q.push_back({1'b0, $urandom});
        send_frame(1'b0, 0, 0);
        k = 0;
        while (rx_q.size() < 4 && k < 200) begin step(); k++; end
        check("pre_reset_streaming", 64'(rx_q.size() >= 4), 64'(1));
        reset = 1'b1;
        step();
        check("midreset_tx_valid", 64'(tx_valid), 64'(0));
        check("midreset_tx_data", 64'(tx_data), 64'(0));
        check("midreset_overflow", 64'(overflow), 64'(0));
        reset = 1'b0;
        rx_q.delete();
        repeat (10) step();
        check("midreset_quiet", 64'(rx_q.size()), 64'(0));
        load_vec(0);
        send_frame(1'b0, 0, 0);
        wait_done(2000, -1);
        compare_rx("post_reset");
        check("post_reset_overflow", 64'(overflow), 64'(0));

        // Randomised frames against the reference model.
        for (int f = 0; f < 20; f++) begin
            rm = 1'($urandom_range(0, 1));
            din_q.delete();
            for (int i = 0; i < $urandom_range(1, 30); i++) begin
                if ($urandom_range(0, 1) != 0) d = {1'($urandom_range(0, 1)), $urandom};
                else                           d = 33'($urandom_range(0, 7));
                din_q.push_back(d);
            end
            model(rm, din_q.size());
            ready_mode = 2;
            send_frame(rm, 30, 0);
            wait_done(4000, -1);
            compare_rx($sformatf("rand%0d", f));
            check($sformatf("rand%0d_overflow", f), 64'(overflow), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
